kernel_pr_start_token_consumer: RTL

- Read side of a dataflow start-token FIFO. Pops one start token per iteration and drives the ap_ctrl_hs start handshake of the downstream process (for example write_back).
- Tracks iterations that are started but not yet done, and limits them to MAX_INFLIGHT.
- Replaces the bare combinational tie of FIFO empty_n to ap_start with a registered, flow-controlled controller.

---
 rtl/kernel_pr_start_token_consumer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/kernel_pr_start_token_consumer.sv
// ----------------------------------------------------------------------------
// kernel_pr_start_token_consumer
//
// Read side of a dataflow start-token FIFO. One start token is popped per
// iteration and turned into an ap_ctrl_hs start request for the downstream
// process. Iterations that have been started (ap_ready seen) but not yet
// finished (ap_done not seen) are counted and limited to MAX_INFLIGHT, so the
// downstream process is never asked to run ahead of its completions.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   if_empty_n    in   start FIFO holds a token
//   if_read       out  pop strobe to the start FIFO (combinational)
//   if_dout       in   token payload at the FIFO head
//   ap_start      out  start request to the downstream process (registered)
//   ap_ready      in   downstream accepted the start
//   ap_done       in   downstream finished one iteration (single-cycle pulse)
//   token_out     out  payload of the current / last popped token
//   inflight      out  started but unfinished iterations
//   iter_count    out  starts accepted since reset (wraps at 2^32)
//   idle          out  nothing pending, nothing in flight, FIFO empty
//   protocol_err  out  sticky: ap_done seen with nothing in flight
// ----------------------------------------------------------------------------
module kernel_pr_start_token_consumer #(
   parameter int DATA_WIDTH   = 1,
   parameter int MAX_INFLIGHT = 2,
   parameter int CNT_W        = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_empty_n,
   output logic                  if_read,
   input  logic [DATA_WIDTH-1:0] if_dout,
   output logic                  ap_start,
   input  logic                  ap_ready,
   input  logic                  ap_done,
   output logic [DATA_WIDTH-1:0] token_out,
   output logic [CNT_W-1:0]      inflight,
   output logic [31:0]           iter_count,
   output logic                  idle,
   output logic                  protocol_err
);

   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_C = '0;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic                    ap_start_q;
   logic [DATA_WIDTH-1:0]   token_q;
   logic [CNT_W-1:0]        inflight_q;
   logic [CNT_W-1:0]        inflight_d;
   logic [31:0]             iter_q;
   logic                    err_q;

   logic                    pop;
   logic                    accept;
   logic                    err_set;

   // ------------------------------------------------------------------------
   // Next-state, pop strobe and in-flight bookkeeping
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      accept     = 1'b0;
      inflight_d = inflight_q;
      err_set    = 1'b0;

      // Pop uses the registered in-flight count: an ap_done that frees a
      // slot this cycle only allows the next pop one cycle later.
      pop    = (state_q == S_IDLE) && if_empty_n && (inflight_q < MAX_C) && !reset;
      accept = (state_q == S_ISSUE) && ap_ready;

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Leaving ISSUE for at least one cycle guarantees a bubble on
            // ap_start between consecutive starts.
            if (ap_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A start accepted together with a done nets to zero; a lone done with
      // nothing in flight is a protocol violation and must not underflow.
      case ({accept, ap_done})
         2'b10: inflight_d = inflight_q + ONE_C;
         2'b01: begin
            if (inflight_q == ZERO_C) begin
               err_set = 1'b1;
            end else begin
               inflight_d = inflight_q - ONE_C;
            end
         end
         default: inflight_d = inflight_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // State and counter registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ap_start_q <= 1'b0;
         token_q    <= '0;
         inflight_q <= '0;
         iter_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         // Registered decode of the next state so ap_start comes straight
         // from a flop.
         ap_start_q <= (state_d == S_ISSUE);
         inflight_q <= inflight_d;
         if (pop) begin
            token_q <= if_dout;
         end
         if (accept) begin
            iter_q <= iter_q + 32'd1;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   assign if_read      = pop;
   assign ap_start     = ap_start_q;
   assign token_out    = token_q;
   assign inflight     = inflight_q;
   assign iter_count   = iter_q;
   assign protocol_err = err_q;
   assign idle         = (state_q == S_IDLE) && (inflight_q == ZERO_C) && !if_empty_n;

endmodule
